// File: rtl/synapse_row_scanner_if.sv
// Bundle of the axon-request, synapse-memory and neuron-dispatch signals around the row scanner.
// The master modport is the scanner itself; the slave modport is its surrounding environment.
interface synapse_row_scanner_if #(
  parameter int unsigned NUM_AXONS   = 256,
  parameter int unsigned NUM_NEURONS = 256
) ();
  localparam int unsigned AW = $clog2(NUM_AXONS);
  localparam int unsigned NW = $clog2(NUM_NEURONS);

  logic                   axon_start;
  logic [AW-1:0]          axon_number;
  logic                   row_rd_en;
  logic [AW-1:0]          row_addr;
  logic [NUM_NEURONS-1:0] row_data;
  logic [NW-1:0]          neuron_number;
  logic                   neuron_number_valid;
  logic                   neuron_ack;
  logic                   synap_done;
  logic                   busy;

  modport master (
    input  axon_start, axon_number, row_data, neuron_ack,
    output row_rd_en, row_addr, neuron_number, neuron_number_valid, synap_done, busy
  );

  modport slave (
    output axon_start, axon_number, row_data, neuron_ack,
    input  row_rd_en, row_addr, neuron_number, neuron_number_valid, synap_done, busy
  );
endinterface

// File: rtl/synapse_row_scanner.sv
// Fetches one axon's connectivity row and dispatches its set bits, lowest index first,
// to the neuron-update controller over a valid/ack handshake.
module synapse_row_scanner #(
  parameter int unsigned NUM_AXONS   = 256,
  parameter int unsigned NUM_NEURONS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  synapse_row_scanner_if.master bus
);
  localparam int unsigned AW = $clog2(NUM_AXONS);
  localparam int unsigned NW = $clog2(NUM_NEURONS);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StScan,
    StWait,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic                   rd_en_q, rd_en_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic [NW-1:0]          num_q, num_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [NW-1:0]          low_idx;

  // Descending sweep so the last hit written is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = NW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    mask_d  = mask_q;
    num_d   = num_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.axon_start) begin
          addr_d  = bus.axon_number;
          rd_en_d = 1'b1;
          done_d  = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        mask_d  = bus.row_data;
        state_d = StScan;
      end
      StScan: begin
        if (mask_q == '0) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          num_d   = low_idx;
          valid_d = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.neuron_ack) begin
          mask_d[num_q] = 1'b0;
          valid_d       = 1'b0;
          state_d       = StScan;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered busy tracks the state being entered so it lines up with the other outputs.
    busy_d = (state_d == StFetch) || (state_d == StLoad) ||
             (state_d == StScan)  || (state_d == StWait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.row_rd_en           = rd_en_q;
  assign bus.row_addr            = addr_q;
  assign bus.neuron_number       = num_q;
  assign bus.neuron_number_valid = valid_q;
  assign bus.synap_done          = done_q;
  assign bus.busy                = busy_q;
endmodule

// File: tb/tb_synapse_row_scanner.sv
// Directed bench for synapse_row_scanner: a queue/countdown reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_synapse_row_scanner;
  localparam int unsigned NA = 256;
  localparam int unsigned NN = 256;
  localparam int unsigned AW = $clog2(NA);
  localparam int Budget = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  synapse_row_scanner_if #(.NUM_AXONS(NA), .NUM_NEURONS(NN)) bus ();

  synapse_row_scanner #(.NUM_AXONS(NA), .NUM_NEURONS(NN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NN-1:0] mem [NA];
  always @(posedge clk) begin
    if (bus.row_rd_en) bus.row_data <= mem[bus.row_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;
  int got[$];
  int rd_pulses;
  int vhold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int got_at(input int i);
    if (i < got.size()) return got[i];
    return -1;
  endfunction

  // Reference model: the row becomes a list of set bits; each entry is presented after a fixed
  // latency and retired by an ack. Phases: 0 idle, 1 working, 2 finished.
  int      m_ph = 0;
  int      m_cd = 0;
  int      m_q[$];
  logic    m_rd = 0, m_valid = 0, m_done = 0, m_busy = 0;
  int      m_addr = 0, m_num = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ph = 0; m_q.delete(); m_rd = 0; m_valid = 0; m_done = 0; m_busy = 0;
        m_addr = 0; m_num = 0;
      end else begin
        m_rd = 0;
        if (m_ph != 1 && bus.axon_start) begin
          m_addr = int'(bus.axon_number);
          m_rd = 1; m_done = 0; m_cd = 3; m_ph = 1;
          m_q.delete();
          for (int i = 0; i < NN; i++) if (mem[m_addr][i]) m_q.push_back(i);
        end else if (m_ph == 1) begin
          if (m_valid) begin
            if (bus.neuron_ack) begin
              void'(m_q.pop_front());
              m_valid = 0; m_cd = 1;
            end
          end else begin
            m_cd--;
            if (m_cd == 0) begin
              if (m_q.size() == 0) begin
                m_done = 1; m_ph = 2;
              end else begin
                m_valid = 1; m_num = m_q[0];
              end
            end
          end
        end
        m_busy = (m_ph == 1);
      end
      chk("rd_en", 32'(bus.row_rd_en), 32'(m_rd));
      chk("row_addr", 32'(bus.row_addr), m_addr);
      chk("valid", 32'(bus.neuron_number_valid), 32'(m_valid));
      chk("done", 32'(bus.synap_done), 32'(m_done));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      if (m_valid) chk("neuron", 32'(bus.neuron_number), m_num);
    end
  end

  // Starts a scan and plays the consumer: ack after the valid has been seen d extra cycles.
  // stray drives ack whenever valid is low; inject fires a start for axon 9 at the first valid.
  task automatic scan(input int axn, input int d, input bit stray, input bit inject,
                      output int cycles);
    int  wcnt;
    bit  injected;
    logic ack_n, start_n;
    got.delete(); rd_pulses = 0; vhold = 0; wcnt = 0; injected = 0;
    @(negedge clk);
    #1;
    bus.axon_start = 1'b1; bus.axon_number = AW'(axn); bus.neuron_ack = stray;
    @(negedge clk);
    cycles = 0;
    while (!bus.synap_done && cycles < Budget) begin
      if (bus.row_rd_en) rd_pulses++;
      ack_n = 1'b0; start_n = 1'b0;
      if (bus.neuron_number_valid) begin
        vhold++;
        if (inject && !injected) begin
          start_n = 1'b1; injected = 1;
        end
        if (wcnt == d) begin
          ack_n = 1'b1; wcnt = 0;
          got.push_back(int'(bus.neuron_number));
        end else begin
          wcnt++;
        end
      end else begin
        ack_n = stray;
      end
      #1;
      bus.neuron_ack = ack_n; bus.axon_start = start_n;
      bus.axon_number = start_n ? AW'(9) : AW'(axn);
      @(negedge clk);
      cycles++;
    end
    chk("scan_timeout", 32'(cycles < Budget), 32'd1);
    #1;
    bus.neuron_ack = 1'b0; bus.axon_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad;
    int w;
    logic [NN-1:0] row;
    rst = 1'b1;
    bus.axon_start = 1'b0; bus.axon_number = '0; bus.neuron_ack = 1'b0; bus.row_data = '0;
    for (int i = 0; i < NA; i++) mem[i] = '0;
    row = '0; row[3] = 1'b1; row[7] = 1'b1; row[255] = 1'b1; mem[5] = row;
    mem[1] = '1;
    row = '0; row[10] = 1'b1; mem[10] = row;
    row = '0; row[1] = 1'b1; row[4] = 1'b1; mem[2] = row;
    row = '0; row[2] = 1'b1; row[6] = 1'b1; mem[3] = row;
    row = '0; row[0] = 1'b1; mem[9] = row;

    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(bus.row_rd_en), 32'd0);
    chk("rst_addr", 32'(bus.row_addr), 32'd0);
    chk("rst_neuron", 32'(bus.neuron_number), 32'd0);
    chk("rst_valid", 32'(bus.neuron_number_valid), 32'd0);
    chk("rst_done", 32'(bus.synap_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    #1 rst = 1'b0;

    // Axon 5, bits {3,7,255}, ack one cycle after each valid.
    scan(5, 1, 1'b0, 1'b0, cyc);
    chk("a_cycles", cyc, 32'd12);
    chk("a_count", got.size(), 32'd3);
    chk("a_n0", got_at(0), 32'd3);
    chk("a_n1", got_at(1), 32'd7);
    chk("a_n2", got_at(2), 32'd255);
    chk("a_rd_pulses", rd_pulses, 32'd1);
    repeat (3) @(negedge clk);
    chk("a_done_held", 32'(bus.synap_done), 32'd1);
    chk("a_addr", 32'(bus.row_addr), 32'd5);

    // Empty row, restarted straight from the finished state.
    scan(0, 0, 1'b0, 1'b0, cyc);
    chk("e_cycles", cyc, 32'd3);
    chk("e_count", got.size(), 32'd0);

    // All-ones row with immediate ack.
    scan(1, 0, 1'b0, 1'b0, cyc);
    chk("f_cycles", cyc, 32'd515);
    chk("f_count", got.size(), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (got_at(i) != i) bad++;
    chk("f_order", bad, 32'd0);

    // Single bit held 20 cycles with stray acks while valid is low.
    scan(10, 20, 1'b1, 1'b0, cyc);
    chk("s_cycles", cyc, 32'd25);
    chk("s_hold", vhold, 32'd21);
    chk("s_count", got.size(), 32'd1);
    chk("s_n0", got_at(0), 32'd10);

    // Start for axon 9 during WAIT on axon 2 must be ignored.
    scan(2, 0, 1'b0, 1'b1, cyc);
    chk("i_cycles", cyc, 32'd7);
    chk("i_count", got.size(), 32'd2);
    chk("i_n0", got_at(0), 32'd1);
    chk("i_n1", got_at(1), 32'd4);
    chk("i_rd_pulses", rd_pulses, 32'd1);
    chk("i_addr", 32'(bus.row_addr), 32'd2);

    // Reset while waiting on the first neuron of axon 3, then rescan.
    @(negedge clk);
    #1 bus.axon_start = 1'b1; bus.axon_number = AW'(3);
    @(negedge clk);
    #1 bus.axon_start = 1'b0;
    w = 0;
    while (!bus.neuron_number_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("r_reach_wait", 32'(bus.neuron_number_valid), 32'd1);
    chk("r_first", 32'(bus.neuron_number), 32'd2);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("r_rd_en", 32'(bus.row_rd_en), 32'd0);
    chk("r_addr", 32'(bus.row_addr), 32'd0);
    chk("r_neuron", 32'(bus.neuron_number), 32'd0);
    chk("r_valid", 32'(bus.neuron_number_valid), 32'd0);
    chk("r_done", 32'(bus.synap_done), 32'd0);
    chk("r_busy", 32'(bus.busy), 32'd0);
    #1 rst = 1'b0;
    scan(3, 0, 1'b0, 1'b0, cyc);
    chk("r_cycles", cyc, 32'd7);
    chk("r_n0", got_at(0), 32'd2);
    chk("r_n1", got_at(1), 32'd6);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
